// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and the units around it.
//   DEF_DATA_W / DEF_ADDR_W : default register width and address width
//   reg_addr_t / reg_data_t : address and data words at the default sizes,
//                             shared by the decoder and the control unit
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one busy bit per register plus a registered popcount.
//   clk, rst           : clock (rising edge), asynchronous active-high reset
//   wr_en, wr_addr     : write-back strobe, clears busy[wr_addr]
//   res_en, res_addr   : reservation strobe, sets busy[res_addr]
//   busy               : busy bit vector, one bit per register
//   busy_cnt           : number of busy bits, updated on the same edge
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0,
  localparam int DEPTH   = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              res_en,
  input  logic [ADDR_W-1:0] res_addr,
  output logic [DEPTH-1:0]  busy,
  output logic [ADDR_W:0]   busy_cnt
);

  logic              set_ok;
  logic              clr_ok;
  logic [DEPTH-1:0]  set_vec;
  logic [DEPTH-1:0]  clr_vec;
  logic [DEPTH-1:0]  busy_next;
  logic              inc;
  logic              dec;
  logic [ADDR_W:0]   cnt_next;

  // Next busy vector and count delta; a reservation wins over a clear on the same address.
  always_comb begin
    set_ok = res_en && !((ZERO_REG != 0) && (res_addr == {ADDR_W{1'b0}}));
    clr_ok = wr_en  && !((ZERO_REG != 0) && (wr_addr  == {ADDR_W{1'b0}}));
    set_vec = set_ok ? ({{(DEPTH-1){1'b0}}, 1'b1} << res_addr) : {DEPTH{1'b0}};
    clr_vec = clr_ok ? ({{(DEPTH-1){1'b0}}, 1'b1} << wr_addr)  : {DEPTH{1'b0}};
    busy_next = (busy & ~clr_vec) | set_vec;
    // Re-reserving a busy register does not count twice.
    inc = set_ok && !busy[res_addr];
    // A clear only decrements if the bit was set and no same-address reservation overrides it.
    dec = clr_ok && busy[wr_addr] && !(set_ok && (res_addr == wr_addr));
    cnt_next = busy_cnt + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
  end

  // Busy bits and count state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= {DEPTH{1'b0}};
      busy_cnt <= {(ADDR_W+1){1'b0}};
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port,
// optional write-to-read bypass, optional hardwired zero register and a
// per-register busy scoreboard.
//   clk, rst               : clock (rising edge), asynchronous active-high reset
//   rd_addr_a/b            : read addresses
//   rd_data_a/b            : read data (combinational)
//   busy_a/b               : reservation outstanding on the addressed register
//   wr_en, wr_addr, wr_data: write port; a write also clears the busy bit
//   res_en, res_addr       : reserve a destination register
//   busy_cnt               : number of busy registers
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              res_en,
  input  logic [ADDR_W-1:0] res_addr,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_ok;

  assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == {ADDR_W{1'b0}}));

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .res_en   (res_en),
    .res_addr (res_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  // Register storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port A. Zero register is checked before bypass so r0 never forwards.
  always_comb begin
    if (rst) begin
      rd_data_a = {DATA_W{1'b0}};
      busy_a    = 1'b0;
    end else if ((ZERO_REG != 0) && (rd_addr_a == {ADDR_W{1'b0}})) begin
      rd_data_a = {DATA_W{1'b0}};
      busy_a    = 1'b0;
    end else if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr_a)) begin
      // Data is being forwarded, so the reader need not stall.
      rd_data_a = wr_data;
      busy_a    = 1'b0;
    end else begin
      rd_data_a = mem[rd_addr_a];
      busy_a    = busy[rd_addr_a];
    end
  end

  // Read port B, same priority as port A.
  always_comb begin
    if (rst) begin
      rd_data_b = {DATA_W{1'b0}};
      busy_b    = 1'b0;
    end else if ((ZERO_REG != 0) && (rd_addr_b == {ADDR_W{1'b0}})) begin
      rd_data_b = {DATA_W{1'b0}};
      busy_b    = 1'b0;
    end else if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
      busy_b    = 1'b0;
    end else begin
      rd_data_b = mem[rd_addr_b];
      busy_b    = busy[rd_addr_b];
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb (ZERO_REG=1, BYPASS=1). Stimulus pushes
// expected values into a queue; a monitor on the falling edge pops and
// compares them against the DUT outputs.
module tb_regfile_sb;

  typedef enum logic [2:0] {SIG_RDA, SIG_RDB, SIG_BUSYA, SIG_BUSYB, SIG_CNT} sig_e;

  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] value;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        busy_a;
  logic        busy_b;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        res_en;
  logic [3:0]  res_addr;
  logic [4:0]  busy_cnt;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  regfile_sb #(
    .DATA_W   (32),
    .ADDR_W   (4),
    .ZERO_REG (1),
    .BYPASS   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .res_en    (res_en),
    .res_addr  (res_addr),
    .busy_cnt  (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string name, input sig_e sig, input logic [31:0] value);
    exp_t e;
    e.name  = name;
    e.sig   = sig;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    res_en = 1'b0;
  endtask

  // Monitor: compare every pending expectation against the settled outputs.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = exp_q.pop_front();
      case (e.sig)
        SIG_RDA:   act = rd_data_a;
        SIG_RDB:   act = rd_data_b;
        SIG_BUSYA: act = {31'd0, busy_a};
        SIG_BUSYB: act = {31'd0, busy_b};
        SIG_CNT:   act = {27'd0, busy_cnt};
        default:   act = 32'hxxxx_xxxx;
      endcase
      checks++;
      if (act !== e.value) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.value);
      end
    end
  end

  initial begin
    // Reset held with a write pending: outputs must read zero, write discarded.
    rst = 1'b1; rd_addr_a = 4'd5; rd_addr_b = 4'd5;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h0000_AAAA;
    res_en = 1'b1; res_addr = 4'd6;
    #1;
    expect_val("rst_rda", SIG_RDA, 32'h0);
    expect_val("rst_busya", SIG_BUSYA, 32'h0);
    expect_val("rst_cnt", SIG_CNT, 32'h0);
    @(negedge clk);
    #1;
    step();
    rst = 1'b0;
    idle();

    // All addresses read zero and not busy after reset.
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i);
      rd_addr_b = 4'(15 - i);
      expect_val("init_rda", SIG_RDA, 32'h0);
      expect_val("init_rdb", SIG_RDB, 32'h0);
      expect_val("init_busya", SIG_BUSYA, 32'h0);
      expect_val("init_busyb", SIG_BUSYB, 32'h0);
      expect_val("init_cnt", SIG_CNT, 32'h0);
      step();
    end

    // Zero register: writes and reservations ignored, no bypass.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h0000_FFFF;
    res_en = 1'b1; res_addr = 4'd0;
    rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    expect_val("r0_nobypass", SIG_RDA, 32'h0);
    expect_val("r0_busy_wcyc", SIG_BUSYA, 32'h0);
    step();
    idle();
    expect_val("r0_rd", SIG_RDB, 32'h0);
    expect_val("r0_busy", SIG_BUSYA, 32'h0);
    expect_val("r0_cnt", SIG_CNT, 32'h0);
    step();

    // Same-cycle bypass of a write, then stored value.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEAD_BEEF;
    rd_addr_a = 4'd5; rd_addr_b = 4'd6;
    expect_val("bypass_rda", SIG_RDA, 32'hDEAD_BEEF);
    expect_val("bypass_other", SIG_RDB, 32'h0);
    step();
    idle();
    rd_addr_b = 4'd5;
    expect_val("stored_rda", SIG_RDA, 32'hDEAD_BEEF);
    expect_val("stored_rdb", SIG_RDB, 32'hDEAD_BEEF);
    step();

    // Reserve r3, then write it back.
    res_en = 1'b1; res_addr = 4'd3; rd_addr_a = 4'd3;
    expect_val("res3_busy_same", SIG_BUSYA, 32'h0);
    expect_val("res3_cnt_same", SIG_CNT, 32'h0);
    step();
    idle();
    expect_val("res3_busy", SIG_BUSYA, 32'h1);
    expect_val("res3_cnt", SIG_CNT, 32'h1);
    step();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h0000_0012; rd_addr_b = 4'd3;
    expect_val("wb3_busya", SIG_BUSYA, 32'h0);
    expect_val("wb3_busyb", SIG_BUSYB, 32'h0);
    expect_val("wb3_rda", SIG_RDA, 32'h0000_0012);
    expect_val("wb3_cnt_wcyc", SIG_CNT, 32'h1);
    step();
    idle();
    expect_val("wb3_cnt", SIG_CNT, 32'h0);
    expect_val("wb3_busy_after", SIG_BUSYA, 32'h0);
    expect_val("wb3_data", SIG_RDA, 32'h0000_0012);
    step();

    // Same-address reserve and write: write lands, reservation wins.
    res_en = 1'b1; res_addr = 4'd7;
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h0000_0055;
    rd_addr_a = 4'd7;
    expect_val("rw7_rda_wcyc", SIG_RDA, 32'h0000_0055);
    expect_val("rw7_busy_wcyc", SIG_BUSYA, 32'h0);
    step();
    idle();
    expect_val("rw7_rda", SIG_RDA, 32'h0000_0055);
    expect_val("rw7_busy", SIG_BUSYA, 32'h1);
    expect_val("rw7_cnt", SIG_CNT, 32'h1);
    step();

    // Make r2 busy, then reserve r1 and write r2 together: count unchanged.
    res_en = 1'b1; res_addr = 4'd2;
    step();
    idle();
    rd_addr_b = 4'd2;
    expect_val("res2_busyb", SIG_BUSYB, 32'h1);
    expect_val("res2_cnt", SIG_CNT, 32'h2);
    step();
    res_en = 1'b1; res_addr = 4'd1;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h0000_0022;
    rd_addr_a = 4'd1;
    expect_val("r1w2_cnt_wcyc", SIG_CNT, 32'h2);
    step();
    idle();
    expect_val("r1w2_cnt", SIG_CNT, 32'h2);
    expect_val("r1w2_busya", SIG_BUSYA, 32'h1);
    expect_val("r1w2_busyb", SIG_BUSYB, 32'h0);
    expect_val("r1w2_rdb", SIG_RDB, 32'h0000_0022);
    step();

    // Re-reserving a busy register is not counted twice.
    res_en = 1'b1; res_addr = 4'd1;
    step();
    idle();
    expect_val("rebusy_cnt", SIG_CNT, 32'h2);
    expect_val("rebusy_busya", SIG_BUSYA, 32'h1);
    step();

    // Busy now {1,7}; add r2 and r4, then reset with a write to r1 pending.
    res_en = 1'b1; res_addr = 4'd2;
    step();
    res_addr = 4'd4;
    expect_val("pre_cnt3", SIG_CNT, 32'h3);
    step();
    idle();
    rd_addr_a = 4'd1; rd_addr_b = 4'd4;
    expect_val("pre_cnt4", SIG_CNT, 32'h4);
    expect_val("pre_busyb4", SIG_BUSYB, 32'h1);
    step();
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'h0000_00AB;
    #1;
    rst = 1'b1;
    expect_val("midrst_rda", SIG_RDA, 32'h0);
    expect_val("midrst_busyb", SIG_BUSYB, 32'h0);
    expect_val("midrst_cnt", SIG_CNT, 32'h0);
    step();
    step();
    rst = 1'b0;
    idle();
    rd_addr_a = 4'd1; rd_addr_b = 4'd7;
    expect_val("postrst_r1", SIG_RDA, 32'h0);
    expect_val("postrst_busya", SIG_BUSYA, 32'h0);
    expect_val("postrst_busyb", SIG_BUSYB, 32'h0);
    expect_val("postrst_r7", SIG_RDB, 32'h0);
    expect_val("postrst_cnt", SIG_CNT, 32'h0);
    step();
    rd_addr_a = 4'd5;
    expect_val("postrst_r5", SIG_RDA, 32'h0);
    step();

    // Bounded drain of the expectation queue.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
